timer: RTL and testbench
========================

# timer

Programmable two-stage interval timer with a small register interface. A prescaled tick drives a 4-bit first-stage counter that produces the `tout_10` pulse train. A 4-bit second-stage counter then divides `tout_10` events to produce `tout_100`. Software starts, stops and clears the counters and sets the periods through three 8-bit registers; the block sits on the local peripheral bus beside other simple slaves.

## Interface
- No parameters; widths fixed (counters 4 bit, address 2 bit, data 8 bit).
- `clk`  in  1  system clock, 1 MHz nominal (1 µs period).
- `rst`  in  1  asynchronous reset, active-high; clears all state immediately.
- `sel`  in  1  tick select: 0 = tick every clk (1 MHz), 1 = tick every 2nd clk (0.5 MHz).
- `write`  in  1  register write strobe, sampled on rising `clk`.
- `read`  in  1  register read enable.
- `addr`  in  2  register address.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data.
- `tout_10`  out  1  first-stage timeout pulse.
- `tout_100`  out  1  second-stage timeout pulse.

## Operation
- Registers:
  - `00` STARTSTOP, reset 0x00: bit0 `start` = count enable; bit7 `cntclr` = counter clear; bits 6:1 read as 0.
  - `01` TIMER1, reset 0x99: [3:0] N1, [7:4] N2.
  - `10` TIMER2, reset 0x99: [3:0] CMP phase compare; [7:4] stored and read back, no function.
  - `11`: writes ignored, reads 0x00.
- Write: on rising `clk` with `write`=1, `wdata` is loaded into the register selected by `addr`.
- Read: `rdata` = selected register while `read`=1 (combinational), else 0x00.
- Tick generator:
  - `sel`=0: tick every clk.
  - `sel`=1: 1-bit toggle divider; tick on alternate clks.
  - Divider is cleared with the counters.
- `cnt1`: 0..N1. Advances on tick when `start`=1; wraps to 0 when `cnt1`>=N1, which also covers N1 lowered below the current count.
- `cnt2`: 0..N2. Advances each time `cnt1` wraps; wraps to 0 when `cnt2`>=N2.
- Outputs:
  - `tout_10`: registered one-clk pulse on each tick where `start`=1 and `cnt1`==CMP.
  - `tout_100`: same condition, additionally requiring `cnt2`==N2.
  - CMP>N1: both outputs stay 0.
- Periods: `tout_10` = (N1+1) ticks; `tout_100` = (N1+1)(N2+1) ticks.
  - Defaults at 1 MHz: 10 µs / 100 µs.
  - TIMER1=0x49: 10 µs / 50 µs.
- `cntclr`=1:
  - `cnt1`, `cnt2` and the divider are held at 0; no pulses.
  - Has priority over `start`.
  - Level-sensitive; stays active until rewritten to 0.
- `start`=0 with `cntclr`=0: counters freeze at their current values; outputs 0.
- Period registers change between ticks; the new value applies from the next tick.

## Timing
- Reset: `tout_10`=`tout_100`=0, `rdata`=0x00, counters and divider 0, registers at their reset values.
- Register write takes effect at the `clk` edge where `write`=1.
- `rdata` is valid in the same cycle `read` rises; no wait states.
- Output pulse is high exactly one clk, asserted the clk after the qualifying tick edge; with `sel`=1 it is still one clk wide.
- First `tout_10` after writing `start`=1 from cleared counters: CMP+1 ticks after the enabling write edge.
- `sel` change mid-count: no counter reset; subsequent ticks use the new rate.
- Simultaneous `write` and `read` to the same address: `rdata` shows the old value in that cycle.

## Configuration
- `TIMER_CLKSEL_EN` defined: `sel` prescaler is present as described.
- Undefined: `sel` is ignored, tick = every clk, and the divider is removed.

## Test plan
- Reset then read addresses 00/01/10 -> 0x00/0x99/0x99; address 11 -> 0x00; outputs 0.
- Write 00=0x80, then 00=0x01, 01=0x49, 10=0x09, `sel`=0 -> reads 0x01/0x49/0x09; `tout_10` rising edges every 10 µs ±1 ns; `tout_100` every 50 µs for ≥300 µs.
- Same setup, TIMER1=0x99 -> `tout_100` period 100 µs.
- `sel`=1, TIMER1=0x99 -> `tout_10` 20 µs, `tout_100` 200 µs, each pulse 1 clk wide.
- Running timer, write 00=0x81 -> no pulses, counters 0. Then write 00=0x01 -> first `tout_10` after CMP+1 ticks.
- Assert `rst` mid-count -> outputs drop immediately and registers return to defaults. Write TIMER2=0x0A with N1=9 -> no pulses.

Source files
------------

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
// Module   : timer
// Purpose  : Two-stage programmable interval timer with an 8-bit register
//            interface. A prescaled tick advances cnt1 (0..N1). Each cnt1
//            wrap advances cnt2 (0..N2). tout_10 pulses when cnt1 == CMP.
//            tout_100 pulses when, in addition, cnt2 == N2.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            sel      - tick select (0: every clk, 1: every 2nd clk)
//            write    - register write strobe
//            read     - register read enable
//            addr     - register address (00 STARTSTOP, 01 TIMER1, 10 TIMER2)
//            wdata    - write data
//            rdata    - read data (combinational, 0x00 when not reading)
//            tout_10  - first-stage one-clk timeout pulse
//            tout_100 - second-stage one-clk timeout pulse
// Config   : TIMER_CLKSEL_EN - when defined, sel selects a /2 tick prescaler.
//            When undefined, sel is ignored and the tick occurs on every clk.
// Revision : 1.0 - initial release
// ============================================================================
module timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       write,
  input  logic       read,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tout_10,
  output logic       tout_100
);

  localparam logic [1:0] C_ADDR_CTRL = 2'b00;
  localparam logic [1:0] C_ADDR_TMR1 = 2'b01;
  localparam logic [1:0] C_ADDR_TMR2 = 2'b10;

  // Register file
  logic       start_q;
  logic       cntclr_q;
  logic [7:0] tmr1_q;
  logic [7:0] tmr2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q  <= 1'b0;
      cntclr_q <= 1'b0;
      tmr1_q   <= 8'h99;
      tmr2_q   <= 8'h99;
    end else if (write) begin
      case (addr)
        C_ADDR_CTRL: begin
          start_q  <= wdata[0];
          cntclr_q <= wdata[7];
        end
        C_ADDR_TMR1: tmr1_q <= wdata;
        C_ADDR_TMR2: tmr2_q <= wdata;
        default: ;
      endcase
    end
  end

  // Reads come straight from the register outputs, so a write in the same
  // cycle is not yet visible.
  always_comb begin
    rdata = 8'h00;
    if (read) begin
      case (addr)
        C_ADDR_CTRL: rdata = {cntclr_q, 6'b000000, start_q};
        C_ADDR_TMR1: rdata = tmr1_q;
        C_ADDR_TMR2: rdata = tmr2_q;
        default:     rdata = 8'h00;
      endcase
    end
  end

  logic [3:0] n1;
  logic [3:0] n2;
  logic [3:0] cmp;
  logic       run;
  logic       tick;

  assign n1  = tmr1_q[3:0];
  assign n2  = tmr1_q[7:4];
  assign cmp = tmr2_q[3:0];
  assign run = start_q & ~cntclr_q;

`ifdef TIMER_CLKSEL_EN
  // Toggle divider: the tick fires on the clk where div_q is 1. It is held at
  // 0 while cleared, so the first tick at sel=1 lands on the second clk.
  logic div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 1'b0;
    end else if (cntclr_q) begin
      div_q <= 1'b0;
    end else if (run) begin
      div_q <= ~div_q;
    end
  end

  assign tick = sel ? div_q : 1'b1;
`else
  logic unused_sel;
  assign unused_sel = sel;
  assign tick       = 1'b1;
`endif

  // Counters and output pulse generation
  logic [3:0] cnt1_q, cnt1_d;
  logic [3:0] cnt2_q, cnt2_d;
  logic       t10_q,  t10_d;
  logic       t100_q, t100_d;
  logic       wrap1;
  logic       hit;

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    t10_d  = 1'b0;
    t100_d = 1'b0;
    // ">=" rather than "==" so a count stranded above a newly lowered N1
    // wraps on the next tick instead of running through 15.
    wrap1  = (cnt1_q >= n1);
    // CMP beyond N1 is an unreachable phase; suppress a stray match on a
    // count left over from a larger N1.
    hit    = (cnt1_q == cmp) && (cmp <= n1);
    if (cntclr_q) begin
      cnt1_d = 4'd0;
      cnt2_d = 4'd0;
    end else if (run && tick) begin
      cnt1_d = wrap1 ? 4'd0 : cnt1_q + 4'd1;
      if (wrap1) begin
        cnt2_d = (cnt2_q >= n2) ? 4'd0 : cnt2_q + 4'd1;
      end
      t10_d  = hit;
      t100_d = hit && (cnt2_q == n2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_q <= 4'd0;
      cnt2_q <= 4'd0;
      t10_q  <= 1'b0;
      t100_q <= 1'b0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      t10_q  <= t10_d;
      t100_q <= t100_d;
    end
  end

  assign tout_10  = t10_q;
  assign tout_100 = t100_q;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer
// Purpose  : Directed self-checking bench for timer. Expected register reads
//            and expected pulse cycle numbers are queued as stimulus is
//            applied. They are then popped against what the DUT produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer;

`ifdef TIMER_CLKSEL_EN
  localparam int RATE = 2;
`else
  localparam int RATE = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [1:0] addr = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       tout_10;
  logic       tout_100;

  timer dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .write    (write),
    .read     (read),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tout_10  (tout_10),
    .tout_100 (tout_100)
  );

  always #500 clk = ~clk;  // 1 us period, timescale 1ns assumed

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // number of rising edges seen so far
  int last_k = 0;  // edge number of the most recent register write
  int k_lo  = 0;
  int k_hi  = -1;

  logic [7:0] sb_rd[$];
  int e10[$], e100[$], o10[$], o100[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records the edge number after which each pulse is high.
  always @(negedge clk) begin
    if (cyc > k_lo && cyc <= k_hi) begin
      if (tout_10 === 1'b1)  o10.push_back(cyc);
      if (tout_100 === 1'b1) o100.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    write = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    write  = 1'b0;
    last_k = cyc;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    read = 1'b1; addr = a;
    sb_rd.push_back(exp);
    #1;
    chk(tag, int'(rdata), int'(sb_rd.pop_front()));
    read = 1'b0;
  endtask

  // Queue the expected pulse edges for the window (last_k, last_k+len]. Run the
  // window, then pop each expectation against the observed list. A period of 0
  // means that no pulse is expected.
  task automatic pulse_window(input string tag, input int f10, input int p10,
                              input int f100, input int p100, input int len);
    o10.delete(); o100.delete();
    k_lo = last_k;
    k_hi = last_k + len;
    if (p10 > 0)
      for (int t = last_k + f10; t <= k_hi; t += p10) e10.push_back(t);
    if (p100 > 0)
      for (int t = last_k + f100; t <= k_hi; t += p100) e100.push_back(t);
    while (cyc <= k_hi + 1) @(negedge clk);
    while (e10.size() > 0) begin
      int t;
      t = e10.pop_front();
      chk({tag, " tout_10 edge"}, (o10.size() > 0) ? o10.pop_front() : -1, t);
    end
    chk({tag, " tout_10 extra pulses"}, o10.size(), 0);
    while (e100.size() > 0) begin
      int t;
      t = e100.pop_front();
      chk({tag, " tout_100 edge"}, (o100.size() > 0) ? o100.pop_front() : -1, t);
    end
    chk({tag, " tout_100 extra pulses"}, o100.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset tout_10", int'(tout_10), 0);
    chk("reset tout_100", int'(tout_100), 0);
    chk("rdata idle", int'(rdata), 0);
    rd("reset rd 00", 2'b00, 8'h00);
    rd("reset rd 01", 2'b01, 8'h99);
    rd("reset rd 10", 2'b10, 8'h99);
    rd("reset rd 11", 2'b11, 8'h00);

    // N1=9 N2=4 CMP=9 at sel=0. This gives 10-cycle and 50-cycle periods.
    wr(2'b00, 8'h80);
    // A simultaneous write and read returns the old value.
    @(negedge clk);
    write = 1'b1; read = 1'b1; addr = 2'b01; wdata = 8'h49;
    sb_rd.push_back(8'h99);
    #1;
    chk("wr+rd old value", int'(rdata), int'(sb_rd.pop_front()));
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
    wr(2'b10, 8'h09);
    wr(2'b11, 8'h5A);
    wr(2'b00, 8'h01);
    rd("cfg rd 00", 2'b00, 8'h01);
    rd("cfg rd 01", 2'b01, 8'h49);
    rd("cfg rd 10", 2'b10, 8'h09);
    rd("cfg rd 11", 2'b11, 8'h00);
    pulse_window("t49", 10, 10, 50, 50, 300);

    // TIMER1 = 0x99 gives a 100-cycle tout_100 period.
    wr(2'b00, 8'h80);
    wr(2'b01, 8'h99);
    wr(2'b00, 8'h01);
    pulse_window("t99", 10, 10, 100, 100, 300);

    // sel=1 halves the tick rate. This holds only with the prescaler built in.
    wr(2'b00, 8'h80);
    sel = 1'b1;
    wr(2'b00, 8'h01);
    pulse_window("sel1", 10 * RATE, 10 * RATE, 100 * RATE, 100 * RATE, 210 * RATE);

    // Clear while running gives no pulses. Restarting with CMP=3 puts the
    // first tout_10 at CMP+1 ticks.
    wr(2'b00, 8'h81);
    rd("clr rd 00", 2'b00, 8'h81);
    pulse_window("clr", 0, 0, 0, 0, 60);
    sel = 1'b0;
    wr(2'b10, 8'h03);
    wr(2'b00, 8'h01);
    pulse_window("restart", 4, 10, 94, 100, 200);

    // Asynchronous reset in the middle of a pulse
    for (int i = 0; i < 40 && tout_10 !== 1'b1; i++) @(negedge clk);
    chk("pulse before rst", int'(tout_10), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst drops tout_10", int'(tout_10), 0);
    chk("rst tout_100", int'(tout_100), 0);
    rd("rst rd 00", 2'b00, 8'h00);
    rd("rst rd 01", 2'b01, 8'h99);
    rd("rst rd 10", 2'b10, 8'h99);
    @(negedge clk);
    rst = 1'b0;

    // CMP=0xA is above N1=9, so no pulses occur.
    wr(2'b10, 8'h5A);
    rd("cmp>n1 rd 10", 2'b10, 8'h5A);
    wr(2'b00, 8'h01);
    pulse_window("cmp>n1", 0, 0, 0, 0, 120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
